// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_pkg
// Brief    : Shared phase encodings and constants for the LED pattern sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

    localparam int c_PHASE_W          = 2;
    localparam int c_TICK_DIV_DEFAULT = 25_000_000;

    typedef enum logic [c_PHASE_W-1:0] {
        PH_FILL  = 2'd0,
        PH_DRAIN = 2'd1,
        PH_SHIFT = 2'd2,
        PH_BLINK = 2'd3
    } phase_e;

    // Step-counter width: must hold max(width, 2*blink_n)-1, never narrower than 1 bit.
    function automatic int idx_width(input int width, input int blink_n);
        int m;
        m = (width > 2 * blink_n) ? width : 2 * blink_n;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_div.sv
`default_nettype none
// ============================================================================
// Module   : led_tick_div
// Brief    : Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module led_tick_div
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = c_TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int                 c_CNT_W    = $clog2(TICK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TICK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    assign tick = en && (r_cnt == c_CNT_LAST);

    // clear wins over counting and works regardless of en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_sequencer
// Brief    : 8-LED light show: fill, drain, walking LED, then blink.
//            Macro LED_SEQ_BLINK_EN includes the BLINK phase; without it
//            SHIFT returns straight to FILL.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = c_TICK_DIV_DEFAULT,
    parameter int BLINK_N  = 3
) (
    input  logic                 clk_50M,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 restart,
    output logic [WIDTH-1:0]     out,
    output logic [c_PHASE_W-1:0] phase,
    output logic                 step,
    output logic                 wrap
);

    localparam int                 c_IDX_W    = idx_width(WIDTH, BLINK_N);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_ONE      = WIDTH'(1);
`ifdef LED_SEQ_BLINK_EN
    localparam logic [c_IDX_W-1:0] c_BLINK_LAST = c_IDX_W'(2 * BLINK_N - 1);
`endif

    phase_e             r_phase, w_phase_nxt;
    logic [c_IDX_W-1:0] r_idx,   w_idx_nxt;
    logic [WIDTH-1:0]   r_out,   w_out_nxt;
    logic               r_step,  w_step_nxt;
    logic               r_wrap,  w_wrap_nxt;
    logic               w_tick;

    led_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk   (clk_50M),
        .rst_n (reset),
        .en    (en),
        .clear (restart),
        .tick  (w_tick)
    );

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            r_phase <= PH_FILL;
            r_idx   <= '0;
            r_out   <= '0;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_idx   <= w_idx_nxt;
            r_out   <= w_out_nxt;
            r_step  <= w_step_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_idx_nxt   = r_idx;
        w_out_nxt   = r_out;
        w_step_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        if (restart) begin
            w_phase_nxt = PH_FILL;
            w_idx_nxt   = '0;
            w_out_nxt   = '0;
        end else if (w_tick) begin
            w_step_nxt = 1'b1;
            w_idx_nxt  = r_idx + 1'b1;
            case (r_phase)
                PH_FILL: begin
                    w_out_nxt = (r_idx == '0) ? c_ONE : {r_out[WIDTH-2:0], 1'b1};
                    if (r_idx == c_IDX_LAST) begin
                        w_phase_nxt = PH_DRAIN;
                        w_idx_nxt   = '0;
                    end
                end
                PH_DRAIN: begin
                    w_out_nxt = {r_out[WIDTH-2:0], 1'b0};
                    if (r_idx == c_IDX_LAST) begin
                        w_phase_nxt = PH_SHIFT;
                        w_idx_nxt   = '0;
                    end
                end
                PH_SHIFT: begin
                    w_out_nxt = (r_idx == '0) ? c_ONE : (r_out << 1);
                    if (r_idx == c_IDX_LAST) begin
                        w_idx_nxt = '0;
`ifdef LED_SEQ_BLINK_EN
                        w_phase_nxt = PH_BLINK;
`else
                        w_phase_nxt = PH_FILL;
                        w_wrap_nxt  = 1'b1;
`endif
                    end
                end
`ifdef LED_SEQ_BLINK_EN
                PH_BLINK: begin
                    // even steps light everything, odd steps go dark
                    w_out_nxt = r_idx[0] ? '0 : '1;
                    if (r_idx == c_BLINK_LAST) begin
                        w_phase_nxt = PH_FILL;
                        w_idx_nxt   = '0;
                        w_wrap_nxt  = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign out   = r_out;
    assign phase = r_phase;
    assign step  = r_step;
    assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_sequencer
// Brief    : Table-driven check of the light show plus restart/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_sequencer;

    localparam int W  = 8;
    localparam int TD = 4;
    localparam int BN = 2;
`ifdef LED_SEQ_BLINK_EN
    localparam int NT = 29;
`else
    localparam int NT = 25;
`endif

    logic         clk_50M = 1'b0;
    logic         reset   = 1'b0;
    logic         en      = 1'b0;
    logic         restart = 1'b0;
    logic [W-1:0] out;
    logic [1:0]   phase;
    logic         step;
    logic         wrap;

    int total = 0;
    int bad   = 0;

    always #5 clk_50M = ~clk_50M;

    led_pattern_sequencer #(
        .WIDTH    (W),
        .TICK_DIV (TD),
        .BLINK_N  (BN)
    ) dut (
        .clk_50M (clk_50M),
        .reset   (reset),
        .en      (en),
        .restart (restart),
        .out     (out),
        .phase   (phase),
        .step    (step),
        .wrap    (wrap)
    );

    // gap = en-low cycles inserted right before this tick
    typedef struct {
        int         gap;
        logic [7:0] out;
        logic [1:0] phase;
        logic       wrap;
    } vec_t;

    vec_t tbl [NT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic edge_();
        @(posedge clk_50M);
        #1;
    endtask

    // Advance until step is seen (bounded); returns edges taken.
    task automatic wait_step(output int n);
        n = 0;
        do begin
            edge_();
            n++;
            if (!step) chk("idle_wrap", 32'(wrap), 32'd0);
        end while (!step && n < 12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] prev;

        tbl[0]  = '{0,  8'h01, 2'd0, 1'b0};
        tbl[1]  = '{0,  8'h03, 2'd0, 1'b0};
        tbl[2]  = '{0,  8'h07, 2'd0, 1'b0};
        tbl[3]  = '{0,  8'h0F, 2'd0, 1'b0};
        tbl[4]  = '{0,  8'h1F, 2'd0, 1'b0};
        tbl[5]  = '{0,  8'h3F, 2'd0, 1'b0};
        tbl[6]  = '{0,  8'h7F, 2'd0, 1'b0};
        tbl[7]  = '{0,  8'hFF, 2'd1, 1'b0};
        tbl[8]  = '{0,  8'hFE, 2'd1, 1'b0};
        tbl[9]  = '{0,  8'hFC, 2'd1, 1'b0};
        tbl[10] = '{10, 8'hF8, 2'd1, 1'b0};
        tbl[11] = '{0,  8'hF0, 2'd1, 1'b0};
        tbl[12] = '{0,  8'hE0, 2'd1, 1'b0};
        tbl[13] = '{0,  8'hC0, 2'd1, 1'b0};
        tbl[14] = '{0,  8'h80, 2'd1, 1'b0};
        tbl[15] = '{0,  8'h00, 2'd2, 1'b0};
        tbl[16] = '{0,  8'h01, 2'd2, 1'b0};
        tbl[17] = '{0,  8'h02, 2'd2, 1'b0};
        tbl[18] = '{3,  8'h04, 2'd2, 1'b0};
        tbl[19] = '{0,  8'h08, 2'd2, 1'b0};
        tbl[20] = '{0,  8'h10, 2'd2, 1'b0};
        tbl[21] = '{0,  8'h20, 2'd2, 1'b0};
        tbl[22] = '{0,  8'h40, 2'd2, 1'b0};
`ifdef LED_SEQ_BLINK_EN
        tbl[23] = '{0,  8'h80, 2'd3, 1'b0};
        tbl[24] = '{0,  8'hFF, 2'd3, 1'b0};
        tbl[25] = '{0,  8'h00, 2'd3, 1'b0};
        tbl[26] = '{0,  8'hFF, 2'd3, 1'b0};
        tbl[27] = '{0,  8'h00, 2'd0, 1'b1};
        tbl[28] = '{0,  8'h01, 2'd0, 1'b0};
`else
        tbl[23] = '{0,  8'h80, 2'd0, 1'b1};
        tbl[24] = '{0,  8'h01, 2'd0, 1'b0};
`endif

        // Reset state
        #12;
        chk("rst_out",   32'(out),   32'h00);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_step",  32'(step),  32'd0);
        chk("rst_wrap",  32'(wrap),  32'd0);

        reset = 1'b1;
        en    = 1'b1;

        // One full show plus the first step of the next one
        prev = 8'h00;
        for (int i = 0; i < NT; i++) begin
            if (tbl[i].gap > 0) begin
                en = 1'b0;
                for (int g = 0; g < tbl[i].gap; g++) begin
                    edge_();
                    chk("hold_out",  32'(out),  32'(prev));
                    chk("hold_step", 32'(step), 32'd0);
                end
                en = 1'b1;
            end
            wait_step(n);
            chk($sformatf("latency[%0d]", i), 32'(n),           32'(TD));
            chk($sformatf("out[%0d]", i),     32'(out),         32'(tbl[i].out));
            chk($sformatf("phase[%0d]", i),   32'(phase),       32'(tbl[i].phase));
            chk($sformatf("wrap[%0d]", i),    32'(wrap),        32'(tbl[i].wrap));
            prev = tbl[i].out;
        end

        // Restart on a tick cycle during SHIFT
        reset = 1'b0;
        edge_();
        reset = 1'b1;
        for (int i = 0; i < 18; i++) wait_step(n);
        chk("pre_rs_out",   32'(out),   32'h02);
        chk("pre_rs_phase", 32'(phase), 32'd2);
        edge_();
        edge_();
        edge_();
        restart = 1'b1;
        edge_();
        restart = 1'b0;
        chk("rs_out",   32'(out),   32'h00);
        chk("rs_phase", 32'(phase), 32'd0);
        chk("rs_step",  32'(step),  32'd0);
        chk("rs_wrap",  32'(wrap),  32'd0);
        wait_step(n);
        chk("rs_latency", 32'(n),   32'(TD));
        chk("rs_first",   32'(out), 32'h01);

        // Restart while frozen is still honoured
        en = 1'b0;
        edge_();
        restart = 1'b1;
        edge_();
        restart = 1'b0;
        chk("rs_en0_out", 32'(out), 32'h00);
        en = 1'b1;
        wait_step(n);
        chk("rs_en0_latency", 32'(n),   32'(TD));
        chk("rs_en0_first",   32'(out), 32'h01);

        // Asynchronous reset between edges in the last phase
`ifdef LED_SEQ_BLINK_EN
        for (int i = 0; i < 24; i++) wait_step(n);
        chk("pre_ar_out",   32'(out),   32'hFF);
        chk("pre_ar_phase", 32'(phase), 32'd3);
`else
        for (int i = 0; i < 19; i++) wait_step(n);
        chk("pre_ar_out",   32'(out),   32'h08);
        chk("pre_ar_phase", 32'(phase), 32'd2);
`endif
        #3;
        reset = 1'b0;
        #1;
        chk("ar_out",   32'(out),   32'h00);
        chk("ar_phase", 32'(phase), 32'd0);
        edge_();
        reset = 1'b1;
        wait_step(n);
        chk("ar_latency", 32'(n),   32'(TD));
        chk("ar_first",   32'(out), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
